phase_measure_ctrl: RTL

- Avalon-MM controlled sequencer for period/phase-difference measurement of two external square waves (coe_S_in1 = reference, coe_S_in2 = measured).
- Software arms a run of N reference periods. The block synchronises the inputs, detects edges, times each period and the in1→in2 rising-edge delay, accumulates sums, and raises done/irq.
- Sits on the SOPC system bus beside the other MyIP cores. Software divides the sums by N.

---
 rtl/phase_measure_ctrl_if.sv | 42 ++++
 rtl/phase_measure_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_measure_ctrl_if.sv
// ----------------------------------------------------------------------------
// phase_measure_ctrl_if
// Avalon-MM slave bus bundle for phase_measure_ctrl.
//
// Signals:
//   avs_chipselect  slave select
//   avs_address     word register address (3 bits)
//   avs_read        read strobe
//   avs_write       write strobe
//   avs_writedata   write data (32 bits)
//   avs_readdata    read data (32 bits), valid in the same cycle as avs_read
//
// Modports:
//   master  bus initiator (system interconnect / testbench)
//   slave   phase_measure_ctrl side
// ----------------------------------------------------------------------------
interface phase_measure_ctrl_if;
    logic        avs_chipselect;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_chipselect,
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_chipselect,
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/phase_measure_ctrl.sv
// ----------------------------------------------------------------------------
// phase_measure_ctrl
// Avalon-MM controlled period / phase-difference measurement sequencer.
// Software arms a run of N reference periods on coe_S_in1; for each period
// the block times the period and the delay from the in1 rising edge to the
// next in2 rising edge, accumulating both into 32-bit saturating sums.
// Software divides the sums by N.
//
// Ports:
//   csi_clk      single system clock, rising edge
//   csi_reset_n  asynchronous active-low reset
//   avs          Avalon-MM slave (phase_measure_ctrl_if.slave)
//   ins_irq      level interrupt, registered DONE & IRQ_EN
//   coe_S_in1    asynchronous reference square wave
//   coe_S_in2    asynchronous measured square wave
//
// Register map (word addresses):
//   0 CTRL/STATUS  W: b0 START, b1 ABORT, b2 IRQ_EN, b3 CLR_DONE
//                  R: b0 BUSY, b1 DONE, b2 IRQ_EN, b3 TIMEOUT, b4 OVF, b5 NO_PH
//   1 NUM_PERIODS  R/W, NUM_W bits, 0 behaves as 1
//   2 TIMEOUT      R/W, cycles from START, 0 disables
//   3 PERIOD_SUM   R
//   4 PHASE_SUM    R
//   5 PERIODS_DONE R
//   6 PERIOD_MIN   R (only with PHASE_MEAS_MINMAX_EN, else reads 0)
//   7 PERIOD_MAX   R (only with PHASE_MEAS_MINMAX_EN, else reads 0)
//
// Build option: define PHASE_MEAS_MINMAX_EN to add the per-period min/max
// tracking registers at addresses 6 and 7.
// ----------------------------------------------------------------------------
module phase_measure_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_W       = 8
) (
    input  logic                 csi_clk,
    input  logic                 csi_reset_n,
    phase_measure_ctrl_if.slave  avs,
    output logic                 ins_irq,
    input  logic                 coe_S_in1,
    input  logic                 coe_S_in2
);

    // A synchroniser shorter than two flops is not safe; clamp silently.
    localparam int          SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [31:0] SAT    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_REF,
        S_MEASURE
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Input synchronisers and rising-edge detection
    // ------------------------------------------------------------------
    logic [SYNC_N-1:0] in1_sync, in2_sync;
    logic              in1_hist, in2_hist;
    logic              ref_e, meas_e;

    // NOTE: clocked state is always assigned with <=, so every flop samples
    // the values from before the edge regardless of statement order.
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            in1_sync <= '0;
            in2_sync <= '0;
            in1_hist <= 1'b0;
            in2_hist <= 1'b0;
        end else begin
            in1_sync <= {in1_sync[SYNC_N-2:0], coe_S_in1};
            in2_sync <= {in2_sync[SYNC_N-2:0], coe_S_in2};
            in1_hist <= in1_sync[SYNC_N-1];
            in2_hist <= in2_sync[SYNC_N-1];
        end
    end

    assign ref_e  = in1_sync[SYNC_N-1] & ~in1_hist;
    assign meas_e = in2_sync[SYNC_N-1] & ~in2_hist;

    // ------------------------------------------------------------------
    // Bus command decode
    // ------------------------------------------------------------------
    logic bus_wr, ctrl_wr;
    logic start_cmd, abort_cmd, clr_cmd;

    assign bus_wr    = avs.avs_chipselect & avs.avs_write;
    assign ctrl_wr   = bus_wr && (avs.avs_address == 3'd0);
    // ABORT dominates a START carried in the same write.
    assign abort_cmd = ctrl_wr & avs.avs_writedata[1];
    assign start_cmd = ctrl_wr & avs.avs_writedata[0] & ~avs.avs_writedata[1];
    assign clr_cmd   = ctrl_wr & avs.avs_writedata[3];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic             irq_en_q, done_q, to_flag_q, ovf_q, no_ph_q;
    logic [NUM_W-1:0] num_q, periods_done_q;
    logic [31:0]      timeout_q, to_cnt_q;
    logic [31:0]      period_sum_q, phase_sum_q;
    logic [31:0]      cnt_q, ph_q;
    logic             ph_seen_q;
`ifdef PHASE_MEAS_MINMAX_EN
    logic [31:0]      per_min_q, per_max_q;
`endif

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic             busy;
    logic             to_hit;
    logic             period_end, last_period;
    logic [NUM_W-1:0] n_eff;
    logic [NUM_W:0]   pd_next;
    logic             cnt_sat;
    logic [31:0]      elapsed;
    logic [31:0]      ph_term;
    logic [32:0]      per_sum_w, ph_sum_w;

    assign busy   = (state_q != S_IDLE);
    assign to_hit = busy && (timeout_q != 32'd0) && (to_cnt_q == timeout_q);
    assign n_eff  = (num_q == '0) ? NUM_W'(1) : num_q;

    // Clocks elapsed since the period's reference edge, counting the current
    // cycle: both the period length and the in1->in2 delay use this value,
    // so a delay of k clocks reads as k and a full period as its length.
    assign cnt_sat = (cnt_q == SAT);
    assign elapsed = cnt_sat ? SAT : cnt_q + 32'd1;

    assign ph_term   = ph_seen_q ? ph_q : 32'd0;
    assign per_sum_w = {1'b0, period_sum_q} + {1'b0, elapsed};
    assign ph_sum_w  = {1'b0, phase_sum_q} + {1'b0, ph_term};

    // A timeout or abort in the same cycle swallows the completing period.
    assign period_end  = (state_q == S_MEASURE) && ref_e && !to_hit && !abort_cmd;
    assign pd_next     = {1'b0, periods_done_q} + {{NUM_W{1'b0}}, 1'b1};
    assign last_period = period_end && (pd_next >= {1'b0, n_eff});

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: next-state is assigned a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (start_cmd)   state_d = S_WAIT_REF;
            S_WAIT_REF: if (ref_e)       state_d = S_MEASURE;
            S_MEASURE:  if (last_period) state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
        if (to_hit)    state_d = S_IDLE;
        if (abort_cmd) state_d = S_IDLE;
    end

    // ------------------------------------------------------------------
    // Control, status and measurement registers
    // ------------------------------------------------------------------
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            irq_en_q       <= 1'b0;
            done_q         <= 1'b0;
            to_flag_q      <= 1'b0;
            ovf_q          <= 1'b0;
            no_ph_q        <= 1'b0;
            num_q          <= NUM_W'(1);
            timeout_q      <= '0;
            to_cnt_q       <= '0;
            period_sum_q   <= '0;
            phase_sum_q    <= '0;
            periods_done_q <= '0;
            cnt_q          <= '0;
            ph_q           <= '0;
            ph_seen_q      <= 1'b0;
            ins_irq        <= 1'b0;
`ifdef PHASE_MEAS_MINMAX_EN
            per_min_q      <= '0;
            per_max_q      <= '0;
`endif
        end else begin
            ins_irq <= done_q & irq_en_q;

            if (ctrl_wr)                                irq_en_q  <= avs.avs_writedata[2];
            if (bus_wr && (avs.avs_address == 3'd1))    num_q     <= avs.avs_writedata[NUM_W-1:0];
            if (bus_wr && (avs.avs_address == 3'd2))    timeout_q <= avs.avs_writedata;
            if (clr_cmd)                                done_q    <= 1'b0;

            if (busy) to_cnt_q <= to_cnt_q + 32'd1;

            unique case (state_q)
                S_IDLE: begin
                    if (start_cmd) begin
                        period_sum_q   <= '0;
                        phase_sum_q    <= '0;
                        periods_done_q <= '0;
                        done_q         <= 1'b0;
                        to_flag_q      <= 1'b0;
                        ovf_q          <= 1'b0;
                        no_ph_q        <= 1'b0;
                        // Starts at 1 so TIMEOUT = T fires T cycles after START.
                        to_cnt_q       <= 32'd1;
`ifdef PHASE_MEAS_MINMAX_EN
                        per_min_q      <= SAT;
                        per_max_q      <= '0;
`endif
                    end
                end

                S_WAIT_REF: begin
                    if (ref_e) begin
                        cnt_q     <= '0;
                        ph_q      <= '0;
                        ph_seen_q <= meas_e;
                    end
                end

                S_MEASURE: begin
                    if (ref_e) begin
                        if (period_end) begin
                            period_sum_q   <= per_sum_w[32] ? SAT : per_sum_w[31:0];
                            phase_sum_q    <= ph_sum_w[32]  ? SAT : ph_sum_w[31:0];
                            if (per_sum_w[32] || ph_sum_w[32]) ovf_q <= 1'b1;
                            if (!ph_seen_q) no_ph_q <= 1'b1;
                            periods_done_q <= pd_next[NUM_W-1:0];
                            if (last_period) done_q <= 1'b1;
`ifdef PHASE_MEAS_MINMAX_EN
                            if (elapsed < per_min_q) per_min_q <= elapsed;
                            if (elapsed > per_max_q) per_max_q <= elapsed;
`endif
                        end
                        // A coincident in2 edge opens the new period at phase 0.
                        cnt_q     <= '0;
                        ph_q      <= '0;
                        ph_seen_q <= meas_e;
                    end else begin
                        if (cnt_sat) begin
                            ovf_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                        if (meas_e && !ph_seen_q) begin
                            ph_q      <= elapsed;
                            ph_seen_q <= 1'b1;
                        end
                    end
                end

                default: ;
            endcase

            if (to_hit && !abort_cmd) begin
                to_flag_q <= 1'b1;
                done_q    <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux: zero wait states, idle bus reads 0
    // ------------------------------------------------------------------
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        if (avs.avs_chipselect && avs.avs_read) begin
            unique case (avs.avs_address)
                3'd0: rdata[5:0]       = {no_ph_q, ovf_q, to_flag_q, irq_en_q, done_q, busy};
                3'd1: rdata[NUM_W-1:0] = num_q;
                3'd2: rdata            = timeout_q;
                3'd3: rdata            = period_sum_q;
                3'd4: rdata            = phase_sum_q;
                3'd5: rdata[NUM_W-1:0] = periods_done_q;
`ifdef PHASE_MEAS_MINMAX_EN
                3'd6: rdata            = per_min_q;
                3'd7: rdata            = per_max_q;
`endif
                default: rdata = '0;
            endcase
        end
    end

    assign avs.avs_readdata = rdata;

endmodule
